pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the five-stage core. Collects stall requests from ID (load-use hazard) and EX (multi-cycle operations), sequences EX multi-cycle ops with an internal down-counter, and performs a one-cycle pipeline flush with PC redirect on an exception from MEM. Drives the per-stage stall vector that holds pc_reg and every inter-stage register (if_id, id_ex, ex_mem, mem_wb).

## Interface
- EXC_VECTOR, 32'h0000_0020, PC loaded on exception flush
- CNT_W, 6, width of multi-cycle length field

- clk  in  1  core clock, rising edge
- Rst_n  in  1  asynchronous, active-high reset (asserted = `RstEnable = 1)
- stallreq_id  in  1  ID load-use hazard, level, combinational from ID
- ex_mc_start  in  1  EX starts multi-cycle op this cycle (one-cycle pulse)
- ex_mc_cycles  in  CNT_W  total stall cycles N for that op, sampled with ex_mc_start
- ex_mc_cancel  in  1  abort in-progress multi-cycle op
- excp_req  in  1  exception detected in MEM (pulse)
- stall  out  6  bit0 pc, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (0)
- flush  out  1  clear all inter-stage registers to NOP
- new_pc  out  32  redirect PC, valid while flush=1, else 0
- ex_mc_done  out  1  one-cycle pulse: multi-cycle op finished, EX result valid
- busy  out  1  high in MC_BUSY

## Operation
- States: IDLE, MC_BUSY, FLUSH. Counter cnt, CNT_W bits.
- stall (combinational):
  - FLUSH or reset: 6'b000000.
  - MC_BUSY, or IDLE with ex_mc_start=1 and N!=0: 6'b001111.
  - else stallreq_id=1: 6'b000111.
  - else 6'b000000.
- IDLE transitions (priority order):
  - excp_req -> FLUSH; any simultaneous start ignored.
  - ex_mc_start, N>=2 -> MC_BUSY, cnt<=N-1.
  - ex_mc_start, N==1 -> stay IDLE, ex_mc_done<=1.
  - ex_mc_start, N==0 -> ignored: no stall, no done.
- MC_BUSY transitions (priority order):
  - excp_req -> FLUSH, counter abandoned, no done.
  - ex_mc_cancel -> IDLE, no done.
  - cnt==1 -> IDLE, ex_mc_done<=1.
  - else cnt<=cnt-1.
  - ex_mc_start in MC_BUSY ignored.
- FLUSH: one cycle; flush=1, new_pc=EXC_VECTOR; -> IDLE unconditionally. excp_req, ex_mc_start and stallreq_id in FLUSH ignored.
- flush, new_pc, ex_mc_done, busy decoded from registered state/flags; no combinational path from inputs.

## Timing
- Reset (async assert): state IDLE, cnt 0, stall 0, flush 0, new_pc 0, ex_mc_done 0, busy 0. Reset mid-MC_BUSY or mid-FLUSH aborts immediately, no done pulse.
- Multi-cycle op, start in cycle 0 with N: stall=001111 in cycles 0..N-1; ex_mc_done=1 and stall released in cycle N.
- Exception: excp_req in cycle k -> flush=1, new_pc=EXC_VECTOR in cycle k+1; normal in k+2.
- stallreq_id: zero-latency, level-for-level, except in FLUSH.

## Structure
- In define.v: `StallBus (5:0), stall codes `StallNone/`StallId (6'b000111)/`StallEx (6'b001111), state encodings, `ExcVector default.
- One natural sub-module: mc_down_counter (load, decrement, terminal-count at 1, clear).

## Test plan
- Reset mid-op: start N=5, assert Rst_n in cycle 2 -> all outputs 0 immediately, no ex_mc_done after release.
- Multi-cycle: start N=4 in cycle 0 -> stall=6'b001111 cycles 0-3, busy cycles 1-3, ex_mc_done=1 only in cycle 4; N=1 -> stall cycle 0 only, done cycle 1; N=0 -> nothing.
- Load-use: stallreq_id high 2 cycles in IDLE -> stall=6'b000111 those 2 cycles; during MC_BUSY -> stall stays 6'b001111.
- Exception: excp_req in cycle 3 of N=6 op -> flush=1, new_pc=32'h20, stall=0 in cycle 4; IDLE cycle 5; no ex_mc_done ever.
- Collision: excp_req with ex_mc_start in IDLE -> FLUSH, start dropped; ex_mc_cancel in MC_BUSY with cnt=3 -> IDLE next cycle, stall released, no done.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  localparam int              DEF_CNT_W      = 6;
  localparam int              STALL_W        = 6;
  localparam logic [31:0]     DEF_EXC_VECTOR = 32'h0000_0020;

  // Per-stage hold masks: bit0 pc, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB.
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_mc_down_counter.sv
// Down-counter sequencing EX multi-cycle ops; terminal count flags the last stall cycle.
// Latency: load/decrement/clear visible one cycle after the request.
// Backpressure: none; clear beats load beats decrement.
module pipe_ctrl_mc_down_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Count register: clear has priority so an aborted op never leaves a stale value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ID/EX stall requests, sequences EX multi-cycle ops, one-cycle flush on MEM exception.
// Latency: stall is zero-latency from inputs; flush/new_pc/ex_mc_done/busy are registered (one cycle after cause).
// Backpressure: stall vector holds pc and inter-stage registers; no input is ever refused except those ignored in FLUSH.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int          CNT_W      = 6
) (
  input  logic             clk,
  input  logic             Rst_n,
  input  logic             stallreq_id,
  input  logic             ex_mc_start,
  input  logic [CNT_W-1:0] ex_mc_cycles,
  input  logic             ex_mc_cancel,
  input  logic             excp_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             ex_mc_done,
  output logic             busy
);

  import pipe_ctrl_pkg::*;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_cnt;
  logic             w_cnt_tc;
  logic             w_len_nz;
  logic             w_len_one;
  logic [CNT_W-1:0] w_load_val;

  assign w_len_nz   = (ex_mc_cycles != '0);
  assign w_len_one  = (ex_mc_cycles == CNT_W'(1));
  // First stall cycle is the start cycle itself, so the counter holds the remaining N-1.
  assign w_load_val = ex_mc_cycles - CNT_W'(1);

  pipe_ctrl_mc_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (Rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_load_val),
    .i_dec      (w_cnt_dec),
    .i_clr      (w_cnt_clr),
    .o_cnt      (w_cnt),
    .o_tc       (w_cnt_tc)
  );

  // State and done-pulse registers; reset aborts any op without a done pulse.
  always_ff @(posedge clk or posedge Rst_n) begin
    if (Rst_n) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and counter control; exception outranks cancel outranks terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_cnt_load  = 1'b0;
    w_cnt_dec   = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (excp_req) begin
          w_state_nxt = ST_FLUSH;
        end else if (ex_mc_start && w_len_nz && !w_len_one) begin
          w_state_nxt = ST_MC_BUSY;
          w_cnt_load  = 1'b1;
        end else if (ex_mc_start && w_len_one) begin
          w_done_nxt  = 1'b1;
        end
      end
      ST_MC_BUSY: begin
        if (excp_req) begin
          w_state_nxt = ST_FLUSH;
          w_cnt_clr   = 1'b1;
        end else if (ex_mc_cancel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_clr   = 1'b1;
        end else if (w_cnt_tc) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_cnt_clr   = 1'b1;
        end else begin
          w_cnt_dec   = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Stall vector: EX hold dominates the ID hold; nothing is held while flushing or in reset.
  always_comb begin
    stall = STALL_NONE;
    if (Rst_n || (r_state == ST_FLUSH)) begin
      stall = STALL_NONE;
    end else if ((r_state == ST_MC_BUSY) ||
                 ((r_state == ST_IDLE) && ex_mc_start && w_len_nz)) begin
      stall = STALL_EX;
    end else if (stallreq_id) begin
      stall = STALL_ID;
    end
  end

  assign flush      = (r_state == ST_FLUSH);
  assign new_pc     = (r_state == ST_FLUSH) ? EXC_VECTOR : 32'h0;
  assign busy       = (r_state == ST_MC_BUSY);
  assign ex_mc_done = r_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed plan cases followed by random traffic.
// Reference model tracks absolute cycle numbers of op end, done pulse and flush.
// Monitor compares every cycle on the falling edge.
module tb_pipe_ctrl;

  localparam logic [31:0] EXC   = 32'h0000_0020;
  localparam logic [5:0]  S_EX  = 6'b001111;
  localparam logic [5:0]  S_ID  = 6'b000111;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        stallreq_id;
  logic        ex_mc_start;
  logic [5:0]  ex_mc_cycles;
  logic        ex_mc_cancel;
  logic        excp_req;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        ex_mc_done;
  logic        busy;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk          (clk),
    .Rst_n        (Rst_n),
    .stallreq_id  (stallreq_id),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_cycles (ex_mc_cycles),
    .ex_mc_cancel (ex_mc_cancel),
    .excp_req     (excp_req),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .ex_mc_done   (ex_mc_done),
    .busy         (busy)
  );

  typedef struct {
    int          cyc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        done;
    logic        busy;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: absolute cycle numbers (-1 = none pending).
  int cyc      = 0;
  int op_start = -1;
  int op_end   = -1;
  int done_at  = -1;
  int flush_at = -1;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, c, act, req);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("stall",      e.cyc, 32'(stall),      32'(e.stall));
      check("flush",      e.cyc, 32'(flush),      32'(e.flush));
      check("new_pc",     e.cyc, new_pc,          e.pc);
      check("ex_mc_done", e.cyc, 32'(ex_mc_done), 32'(e.done));
      check("busy",       e.cyc, 32'(busy),       32'(e.busy));
    end
  end

  // One clock of stimulus: drive inputs, predict outputs, advance the model.
  task automatic drive(input bit rst, input bit id, input bit st, input int n,
                       input bit can, input bit exc);
    exp_t e;
    bit   in_flush;
    bit   in_busy;
    @(posedge clk);
    #1;
    Rst_n        = rst;
    stallreq_id  = id;
    ex_mc_start  = st;
    ex_mc_cycles = 6'(n);
    ex_mc_cancel = can;
    excp_req     = exc;
    e.cyc = cyc;
    if (rst) begin
      e.stall  = 6'b0;
      e.flush  = 1'b0;
      e.pc     = 32'h0;
      e.done   = 1'b0;
      e.busy   = 1'b0;
      op_start = -1;
      op_end   = -1;
      done_at  = -1;
      flush_at = -1;
    end else begin
      in_flush = (cyc == flush_at);
      in_busy  = (cyc > op_start) && (cyc < op_end);
      e.flush  = in_flush;
      e.pc     = in_flush ? EXC : 32'h0;
      e.done   = (cyc == done_at);
      e.busy   = in_busy;
      if (in_flush)                    e.stall = 6'b0;
      else if (in_busy || (st && n != 0)) e.stall = S_EX;
      else if (id)                     e.stall = S_ID;
      else                             e.stall = 6'b0;
      if (in_flush) begin
        // everything ignored while flushing
      end else if (in_busy) begin
        if (exc) begin
          flush_at = cyc + 1;
          op_end   = -1;
          done_at  = -1;
        end else if (can) begin
          op_end   = -1;
          done_at  = -1;
        end
      end else begin
        if (exc) begin
          flush_at = cyc + 1;
        end else if (st && n >= 1) begin
          done_at = cyc + n;
          if (n >= 2) begin
            op_start = cyc;
            op_end   = cyc + n;
          end
        end
      end
    end
    sbq.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst_n = 1'b1; stallreq_id = 0; ex_mc_start = 0; ex_mc_cycles = 0;
    ex_mc_cancel = 0; excp_req = 0;
    // Reset with noisy inputs: outputs must stay zero.
    drive(1, 1, 1, 4, 0, 1);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);
    // N=4, N=1, N=0.
    drive(0, 0, 1, 4, 0, 0); idle(6);
    drive(0, 0, 1, 1, 0, 0); idle(3);
    drive(0, 0, 1, 0, 0, 0); idle(2);
    // Load-use in IDLE, then during MC_BUSY.
    drive(0, 1, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0); idle(2);
    drive(0, 0, 1, 5, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 3, 0, 0);
    idle(4);
    // Exception in cycle 3 of an N=6 op.
    drive(0, 0, 1, 6, 0, 0); idle(2); drive(0, 0, 0, 0, 0, 1); idle(8);
    // Exception collides with start in IDLE.
    drive(0, 0, 1, 3, 0, 1); idle(5);
    // Cancel with three cycles left on the counter.
    drive(0, 0, 1, 5, 0, 0); idle(1); drive(0, 0, 0, 0, 1, 0); idle(6);
    // Cancel on the terminal cycle of an N=2 op beats the done pulse.
    drive(0, 0, 1, 2, 0, 0); drive(0, 0, 0, 0, 1, 0); idle(3);
    // Reset mid-op.
    drive(0, 0, 1, 5, 0, 0); idle(1); drive(1, 0, 0, 0, 0, 0); idle(8);
    // Reset in the cycle a done pulse is due.
    drive(0, 0, 1, 1, 0, 0); drive(1, 0, 0, 0, 0, 0); idle(3);
    // Inputs during FLUSH are ignored.
    drive(0, 0, 0, 0, 0, 1); drive(0, 1, 1, 4, 1, 1); idle(4);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, id, st, can, exc;
      int n;
      r   = ($urandom_range(0, 199) == 0);
      id  = ($urandom_range(0, 2) == 0);
      st  = ($urandom_range(0, 5) == 0);
      can = ($urandom_range(0, 11) == 0);
      exc = ($urandom_range(0, 15) == 0);
      n   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
      drive(r, id, st, n, can, exc);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", cyc, 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
